// File: rtl/snake_control_if.sv
// Bus between the snake core, the game state machine, the direction decoder and the VGA stage.
interface snake_control_if;
  logic [9:0]  ADDR_H;
  logic [8:0]  ADDR_V;
  logic [1:0]  M_STATE;
  logic [1:0]  DIR;
  logic [7:0]  TARGET_H;
  logic [6:0]  TARGET_V;
  logic        REACHED;
  logic [11:0] COLOUR;
  logic        HIT;

  modport master (
    output ADDR_H, ADDR_V, M_STATE, DIR, TARGET_H, TARGET_V,
    input  REACHED, COLOUR, HIT
  );

  modport slave (
    input  ADDR_H, ADDR_V, M_STATE, DIR, TARGET_H, TARGET_V,
    output REACHED, COLOUR, HIT
  );
endinterface

// File: rtl/snake_control.sv
// Snake-game core: moves the snake on a 160x120 grid, flags capture/self-hit,
// and renders the colour of the currently addressed VGA pixel.
module snake_control #(
  parameter int unsigned MOVE_PERIOD = 10_000_000,
  parameter int unsigned MAX_LENGTH  = 20,
  parameter int unsigned INIT_LENGTH = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  snake_control_if.slave  bus
);

  localparam int unsigned CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int unsigned LEN_W = $clog2(MAX_LENGTH + 1);
  localparam int unsigned H_W   = 8;
  localparam int unsigned V_W   = 7;

  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_e;
  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_WIN, ST_LOSE} mstate_e;

  logic [H_W-1:0]   seg_h_q [MAX_LENGTH];
  logic [H_W-1:0]   seg_h_d [MAX_LENGTH];
  logic [V_W-1:0]   seg_v_q [MAX_LENGTH];
  logic [V_W-1:0]   seg_v_d [MAX_LENGTH];
  logic [LEN_W-1:0] len_q, len_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reached_q, reached_d;
  logic             hit_q, hit_d;
  logic [11:0]      colour_q, colour_d;

  mstate_e          m_state;
  dir_e             dir_req;
  logic [H_W-1:0]   head_h;
  logic [V_W-1:0]   head_v;
  logic [H_W-1:0]   cell_h;
  logic [V_W-1:0]   cell_v;
  logic             visible;
  logic             on_body;

  assign m_state = mstate_e'(bus.M_STATE);
  assign dir_req = dir_e'(bus.DIR);

  // Snake state: re-init while idle, advance on counter wrap while playing, freeze otherwise.
  always_comb begin
    seg_h_d   = seg_h_q;
    seg_v_d   = seg_v_q;
    len_d     = len_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    reached_d = 1'b0;
    hit_d     = 1'b0;
    head_h    = seg_h_q[0];
    head_v    = seg_v_q[0];

    case (m_state)
      ST_IDLE: begin
        for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
          seg_h_d[i] = H_W'(80 - i);
          seg_v_d[i] = V_W'(60);
        end
        len_d = LEN_W'(INIT_LENGTH);
        dir_d = DIR_RIGHT;
        cnt_d = '0;
      end
      ST_PLAY: begin
        if (cnt_q == CNT_W'(MOVE_PERIOD - 1)) begin
          cnt_d = '0;
          // A request for the exact reverse direction is dropped.
          dir_d = (dir_req == dir_e'(dir_q ^ 2'd2)) ? dir_q : dir_req;
          case (dir_d)
            DIR_UP:    head_v = (seg_v_q[0] == V_W'(0))   ? V_W'(119) : seg_v_q[0] - V_W'(1);
            DIR_RIGHT: head_h = (seg_h_q[0] == H_W'(159)) ? H_W'(0)   : seg_h_q[0] + H_W'(1);
            DIR_DOWN:  head_v = (seg_v_q[0] == V_W'(119)) ? V_W'(0)   : seg_v_q[0] + V_W'(1);
            default:   head_h = (seg_h_q[0] == H_W'(0))   ? H_W'(159) : seg_h_q[0] - H_W'(1);
          endcase
          for (int unsigned i = 1; i < MAX_LENGTH; i++) begin
            seg_h_d[i] = seg_h_q[i-1];
            seg_v_d[i] = seg_v_q[i-1];
          end
          seg_h_d[0] = head_h;
          seg_v_d[0] = head_v;
          reached_d  = (head_h == bus.TARGET_H) && (head_v == bus.TARGET_V);
          if (reached_d && (len_q < LEN_W'(MAX_LENGTH))) begin
            len_d = len_q + LEN_W'(1);
          end
          // Post-shift segment i holds the pre-shift segment i-1.
          for (int unsigned i = 1; i < MAX_LENGTH; i++) begin
            if ((LEN_W'(i) < len_q) && (seg_h_q[i-1] == head_h) && (seg_v_q[i-1] == head_v)) begin
              hit_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Pixel colour by priority: off-screen, head, body, target, background.
  always_comb begin
    cell_h  = bus.ADDR_H[9:2];
    cell_v  = bus.ADDR_V[8:2];
    visible = (bus.ADDR_H < 10'd640) && (bus.ADDR_V < 9'd480);
    on_body = 1'b0;
    for (int unsigned i = 1; i < MAX_LENGTH; i++) begin
      if ((LEN_W'(i) < len_q) && (seg_h_q[i] == cell_h) && (seg_v_q[i] == cell_v)) begin
        on_body = 1'b1;
      end
    end
    if (!visible) begin
      colour_d = 12'h000;
    end else if ((seg_h_q[0] == cell_h) && (seg_v_q[0] == cell_v)) begin
      colour_d = 12'hFF0;
    end else if (on_body) begin
      colour_d = 12'h0F0;
    end else if ((bus.TARGET_H == cell_h) && (bus.TARGET_V == cell_v)) begin
      colour_d = 12'hF00;
    end else begin
      colour_d = 12'h00F;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
        seg_h_q[i] <= H_W'(80 - i);
        seg_v_q[i] <= V_W'(60);
      end
      len_q     <= LEN_W'(INIT_LENGTH);
      dir_q     <= DIR_RIGHT;
      cnt_q     <= '0;
      reached_q <= 1'b0;
      hit_q     <= 1'b0;
      colour_q  <= 12'h000;
    end else begin
      seg_h_q   <= seg_h_d;
      seg_v_q   <= seg_v_d;
      len_q     <= len_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      reached_q <= reached_d;
      hit_q     <= hit_d;
      colour_q  <= colour_d;
    end
  end

  assign bus.REACHED = reached_q;
  assign bus.HIT     = hit_q;
  assign bus.COLOUR  = colour_q;

endmodule

// File: tb/tb_snake_control.sv
// Directed and randomized checks of snake_control against a queue-based game model.
module tb_snake_control;

  localparam int P    = 4;
  localparam int MAXL = 20;
  localparam int INIT = 4;

  logic CLK = 1'b0;
  logic RESET;

  snake_control_if bus ();

  snake_control #(.MOVE_PERIOD(P), .MAX_LENGTH(MAXL), .INIT_LENGTH(INIT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: the snake as a list of cells, head first; the full register file is kept.
  int qh[$];
  int qv[$];
  int mlen, mdir, mcnt, ticks;
  logic        exp_reached, exp_hit;
  logic [11:0] exp_colour;

  function automatic void model_init();
    qh.delete();
    qv.delete();
    for (int i = 0; i < MAXL; i++) begin
      qh.push_back(80 - i);
      qv.push_back(60);
    end
    mlen = INIT;
    mdir = 1;
    mcnt = 0;
  endfunction

  function automatic logic [11:0] model_colour(int ah, int av, int th, int tv);
    int ch, cv;
    ch = ah / 4;
    cv = av / 4;
    if (ah >= 640 || av >= 480) return 12'h000;
    if (ch == qh[0] && cv == qv[0]) return 12'hFF0;
    for (int i = 1; i < mlen; i++)
      if (ch == qh[i] && cv == qv[i]) return 12'h0F0;
    if (ch == th && cv == tv) return 12'hF00;
    return 12'h00F;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Predict one clock edge from the current inputs, take the edge, compare outputs.
  task automatic step();
    int nh, nv, d;
    exp_reached = 1'b0;
    exp_hit     = 1'b0;
    exp_colour  = RESET ? 12'h000 :
                  model_colour(int'(bus.ADDR_H), int'(bus.ADDR_V), int'(bus.TARGET_H), int'(bus.TARGET_V));
    if (RESET || bus.M_STATE == 2'd0) begin
      model_init();
    end else if (bus.M_STATE == 2'd1) begin
      if (mcnt == P - 1) begin
        mcnt = 0;
        ticks++;
        d = int'(bus.DIR);
        if (d != (mdir + 2) % 4) mdir = d;
        nh = qh[0];
        nv = qv[0];
        case (mdir)
          0:       nv = (nv + 119) % 120;
          1:       nh = (nh + 1) % 160;
          2:       nv = (nv + 1) % 120;
          default: nh = (nh + 159) % 160;
        endcase
        qh.push_front(nh);
        qv.push_front(nv);
        void'(qh.pop_back());
        void'(qv.pop_back());
        for (int i = 1; i < mlen; i++)
          if (qh[i] == nh && qv[i] == nv) exp_hit = 1'b1;
        exp_reached = (nh == int'(bus.TARGET_H)) && (nv == int'(bus.TARGET_V));
        if (exp_reached && mlen < MAXL) mlen++;
      end else begin
        mcnt++;
      end
    end
    @(posedge CLK);
    #1;
    chk("reached", 12'(bus.REACHED), 12'(exp_reached));
    chk("hit",     12'(bus.HIT),     12'(exp_hit));
    chk("colour",  bus.COLOUR,       exp_colour);
  endtask

  task automatic point_seg(input int i);
    bus.ADDR_H = 10'(qh[i] * 4 + int'($urandom_range(0, 3)));
    bus.ADDR_V = 9'(qv[i] * 4 + int'($urandom_range(0, 3)));
  endtask

  task automatic run_ticks(input int d, input int n);
    int t0, guard;
    t0    = ticks;
    guard = 0;
    bus.DIR = 2'(d);
    while (ticks < t0 + n && guard < n * P + P) begin
      point_seg(0);
      step();
      guard++;
    end
    checks++;
    assert (ticks >= t0 + n) else begin
      errors++;
      $error("FAIL tick_budget observed %0d expected %0d", ticks - t0, n);
    end
  endtask

  initial begin
    int guard;
    ticks       = 0;
    RESET       = 1'b1;
    bus.M_STATE = 2'd1;
    bus.DIR     = 2'd1;
    bus.ADDR_H  = 10'd320;
    bus.ADDR_V  = 9'd240;
    bus.TARGET_H = 8'd10;
    bus.TARGET_V = 7'd10;
    model_init();
    step();
    step();
    RESET = 1'b0;

    // First tick moves the head right; colour follows the head cell.
    run_ticks(1, 1);
    bus.ADDR_H = 10'd324;
    bus.ADDR_V = 9'd240;
    step();

    // Reverse request ignored.
    run_ticks(3, 6);

    // Wrap at the right edge.
    guard = 0;
    bus.DIR = 2'd1;
    while (qh[0] != 159 && guard < 1000) begin
      point_seg(0);
      step();
      guard++;
    end
    run_ticks(1, 2);
    bus.ADDR_H = 10'd2;
    bus.ADDR_V = 9'd241;
    step();

    // Frozen in win/lose.
    bus.M_STATE = 2'd2;
    repeat (6) begin point_seg(0); step(); end
    bus.M_STATE = 2'd3;
    repeat (6) begin point_seg(1); step(); end

    // Back to idle: initial snake, background and off-screen colours.
    bus.M_STATE = 2'd0;
    step();
    bus.ADDR_H = 10'd0;   bus.ADDR_V = 9'd0;   step();
    bus.ADDR_H = 10'd700; bus.ADDR_V = 9'd100; step();
    bus.ADDR_H = 10'd320; bus.ADDR_V = 9'd240; step();

    // Capture on the second tick, then render the fifth segment.
    bus.TARGET_H = 8'd82;
    bus.TARGET_V = 7'd60;
    bus.M_STATE  = 2'd1;
    run_ticks(1, 2);
    bus.TARGET_H = 8'd5;
    bus.TARGET_V = 7'd5;
    repeat (3) begin point_seg(4); step(); end

    // Down, left, up re-enters the body.
    run_ticks(2, 1);
    run_ticks(3, 1);
    run_ticks(0, 1);
    run_ticks(0, 2);

    // Randomized play.
    for (int c = 0; c < 1500; c++) begin
      int r;
      RESET = ($urandom_range(0, 299) == 0);
      r = int'($urandom_range(0, 99));
      bus.M_STATE = (r < 2) ? 2'd0 : (r < 5) ? 2'd2 : (r < 8) ? 2'd3 : 2'd1;
      if ($urandom_range(0, 5) == 0) bus.DIR = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 3));
      if (r == 0) point_seg(0);
      else if (r == 1) point_seg(int'($urandom_range(1, MAXL - 1)));
      else begin
        bus.ADDR_H = 10'($urandom_range(0, 799));
        bus.ADDR_V = 9'($urandom_range(0, 524));
      end
      if (mcnt == P - 1 && $urandom_range(0, 2) == 0) begin
        case (int'(bus.DIR))
          0: begin bus.TARGET_H = 8'(qh[0]); bus.TARGET_V = 7'((qv[0] + 119) % 120); end
          1: begin bus.TARGET_H = 8'((qh[0] + 1) % 160); bus.TARGET_V = 7'(qv[0]); end
          2: begin bus.TARGET_H = 8'(qh[0]); bus.TARGET_V = 7'((qv[0] + 1) % 120); end
          default: begin bus.TARGET_H = 8'((qh[0] + 159) % 160); bus.TARGET_V = 7'(qv[0]); end
        endcase
      end else if ($urandom_range(0, 19) == 0) begin
        bus.TARGET_H = 8'($urandom_range(0, 159));
        bus.TARGET_V = 7'($urandom_range(0, 119));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_control.md
# snake_control

Snake-game core. It holds the snake body on a 160x120 cell grid, advances it one cell per move tick in the requested direction, and detects target capture and self-collision. It also renders the snake, target and background colour for the pixel currently addressed by the VGA timing block. It sits between the master game state machine (M_STATE, TARGET_*), the direction decoder (DIR) and the VGA output stage (ADDR_*, COLOUR).

## Interface
Parameters:
- MOVE_PERIOD, 10_000_000: clock cycles between snake moves.
- MAX_LENGTH, 20: number of segment registers.
- INIT_LENGTH, 4: active segments after reset or re-initialisation.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  reset, synchronous and active-high.
- ADDR_H  in  10  current pixel column, 0..799; visible range 0..639.
- ADDR_V  in  9  current pixel row, 0..524; visible range 0..479.
- M_STATE  in  2  master state: 0 = idle, 1 = play, 2 = win, 3 = lose.
- DIR  in  2  requested direction: 0 = up, 1 = right, 2 = down, 3 = left.
- TARGET_H  in  8  target cell column, 0..159.
- TARGET_V  in  7  target cell row, 0..119.
- REACHED  out  1  one-cycle pulse when the head lands on the target.
- COLOUR  out  12  RGB444 colour for the addressed pixel.
- HIT  out  1  one-cycle pulse when the head lands on an active body segment.

## Operation
- Cell size is 4x4 pixels. Cell column = ADDR_H[9:2]; cell row = ADDR_V[8:2].
- Segment arrays: SEG_H[0..MAX_LENGTH-1] (8 b) and SEG_V[..] (7 b). Index 0 is the head. Length register `len` ranges INIT_LENGTH..MAX_LENGTH.
- Initial state (reset, or whenever M_STATE = 0):
  - SEG_H[i] = 80 - i and SEG_V[i] = 60 for all i.
  - len = INIT_LENGTH.
  - Current direction = right (1).
  - Tick counter = 0.
- Move tick: a free-running counter counts 0..MOVE_PERIOD-1, only while M_STATE = 1. A tick occurs when the counter wraps.
- On each tick:
  - Direction update: current direction takes DIR unless DIR is the exact reverse of the current direction; a reverse request is ignored.
  - Body shift: SEG[i] <= SEG[i-1] for i = 1..MAX_LENGTH-1.
  - Head move: up decrements V, down increments V, left decrements H, right increments H.
  - Wrap-around: H 159 -> 0 and 0 -> 159; V 119 -> 0 and 0 -> 119. Walls never cause HIT.
- Capture: if the new head equals (TARGET_H, TARGET_V), REACHED pulses for the cycle after the tick and len increments, saturating at MAX_LENGTH. The newly exposed segment already holds the old tail position, since all segments shift.
- Self-collision: if the new head equals SEG[i] for any 1 <= i < len, computed on post-shift positions, HIT pulses for the cycle after the tick. The block keeps moving until M_STATE leaves 1.
- Capture and collision in the same tick: both pulse.
- M_STATE 2 or 3: snake frozen, counter held, rendering continues.
- Colour priority, evaluated for the addressed cell:
  - Outside the visible area: 12'h000.
  - Head: 12'hFF0.
  - Active body segment (1 <= i < len): 12'h0F0.
  - Target cell: 12'hF00.
  - Otherwise background: 12'h00F.

## Timing
- Reset values: REACHED = 0, HIT = 0, COLOUR = 12'h000. Segment array, len, direction and counter take their initial values.
- COLOUR is registered: it reflects the ADDR_H/ADDR_V sampled on the previous edge, so latency is 1 cycle.
- Segment shift and head update occur on the tick edge. REACHED and HIT are registered compares of the new head, asserted exactly one cycle after the tick edge and held for 1 cycle.
- RESET mid-game: state returns to the initial snake on the next edge, and any pending REACHED/HIT is cleared.
- Changing DIR between ticks has no effect until the next tick; only the DIR value present on the tick edge counts.

## Test plan
Bench uses MOVE_PERIOD = 4.
- Reset, M_STATE = 1, DIR = 1, ADDR = (320,240) -> head moves (80,60) -> (81,60) after the first tick; COLOUR at (324,240) = 12'hFF0 one cycle after addressing.
- M_STATE = 1, DIR = 3 (reverse of right) -> snake keeps moving right and the head H increments each tick.
- Head steered to H = 159 moving right -> next tick head H = 0, HIT stays 0.
- TARGET = (82,60), DIR = 1 from reset -> REACHED pulses for exactly 1 cycle after the second tick; len becomes 5 and the 5th segment renders 12'h0F0.
- Grow to len >= 5, then steer down, left, up in consecutive ticks -> HIT pulses once when the head re-enters a body cell.
- M_STATE = 0 mid-game -> head returns to (80,60), len = 4, direction = right; COLOUR at pixel (0,0) = 12'h00F and at (700,100) = 12'h000.
